qpsk_tx_polyphase: RTL and testbench

//  Parametrised two-channel (I/Q) polyphase RRC pulse-shaping transmit filter.
//  - Takes one bipolar symbol bit per channel per symbol period (1 -> +1, 0 -> -1).
//  - Produces one saturated OS-times-upsampled sample per channel per sample strobe.
//  - Sits between the symbol source (PRBS/mapper) and the channel/DAC path.

---
 rtl/qpsk_tx_pkg.sv | 23 ++
 rtl/qpsk_tx_polyphase_if.sv | 30 +++
 rtl/qpsk_tx_mac.sv | 67 ++++++
 rtl/qpsk_tx_polyphase.sv | 91 +++++++++
 tb/tb_qpsk_tx_polyphase.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/qpsk_tx_pkg.sv
// Shared types, clog2 helper and the default 24-tap RRC set for qpsk_tx_polyphase.
// RRC_24x8 peaks at tap 12 (72) and is symmetric about it; tap 0 sits in the MSBs.
package qpsk_tx_pkg;

    typedef logic sym_t;
    typedef logic signed [7:0] sample_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    localparam logic [191:0] RRC_24x8 = {
        8'hFE, 8'hFE, 8'hFD, 8'hFF, 8'h00, 8'hF8, 8'hF6, 8'hF4,
        8'hFC, 8'h12, 8'h2C, 8'h40, 8'h48, 8'h40, 8'h2C, 8'h12,
        8'hFC, 8'hF4, 8'hF6, 8'hF8, 8'h00, 8'hFF, 8'hFD, 8'hFE
    };

endpackage

// File: rtl/qpsk_tx_polyphase_if.sv
// Symbol-in / sample-out bus of qpsk_tx_polyphase; coefficient write port only with QPSK_TX_COEF_LOAD_EN.
// Latency/backpressure: none here; the source holds symbols until o_sym_rd.
interface qpsk_tx_polyphase_if #(
    parameter int OUT_W  = 8,
    parameter int COEF_W = 8,
    parameter int AW     = 5
);
    logic                     enable;
    logic                     i_sym_i;
    logic                     i_sym_q;
    logic                     o_sym_rd;
    logic signed [OUT_W-1:0]  o_tx_i;
    logic signed [OUT_W-1:0]  o_tx_q;
    logic                     o_valid;
`ifdef QPSK_TX_COEF_LOAD_EN
    logic                     i_coef_we;
    logic [AW-1:0]            i_coef_addr;
    logic signed [COEF_W-1:0] i_coef_data;

    modport master (output enable, i_sym_i, i_sym_q, i_coef_we, i_coef_addr, i_coef_data,
                    input  o_sym_rd, o_tx_i, o_tx_q, o_valid);
    modport slave  (input  enable, i_sym_i, i_sym_q, i_coef_we, i_coef_addr, i_coef_data,
                    output o_sym_rd, o_tx_i, o_tx_q, o_valid);
`else
    modport master (output enable, i_sym_i, i_sym_q,
                    input  o_sym_rd, o_tx_i, o_tx_q, o_valid);
    modport slave  (input  enable, i_sym_i, i_sym_q,
                    output o_sym_rd, o_tx_i, o_tx_q, o_valid);
`endif
endinterface

// File: rtl/qpsk_tx_mac.sv
// One channel of the polyphase shaper: symbol history, phase-selected signed tap sum, saturation.
// Latency 1 clk from en_i to tx_o; no backpressure, all state holds while en_i is low.
module qpsk_tx_mac
    import qpsk_tx_pkg::*;
#(
    parameter  int OS     = 4,
    parameter  int NBAUD  = 6,
    parameter  int COEF_W = 8,
    parameter  int OUT_W  = 8,
    localparam int PW     = clog2(OS)
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en_i,
    input  logic                     shift_i,
    input  logic [PW-1:0]            phase_i,
    input  sym_t                     sym_i,
    input  logic signed [COEF_W-1:0] coef_i [OS*NBAUD],
    output logic signed [OUT_W-1:0]  tx_o
);

    localparam int NTAP  = OS * NBAUD;
    localparam int IW    = clog2(NTAP);
    localparam int ACC_W = COEF_W + clog2(NBAUD) + 1;
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-(2 ** (OUT_W - 1)));

    logic [NBAUD-1:0]         sr_q, sr_d;
    logic signed [OUT_W-1:0]  tx_q, tx_d;
    logic signed [ACC_W-1:0]  acc;
    logic [IW-1:0]            idx;

    // A 0 symbol stands for -1, so its tap is subtracted rather than skipped.
    always_comb begin
        acc = '0;
        idx = '0;
        for (int k = 0; k < NBAUD; k++) begin
            idx = IW'(k * OS) + IW'(phase_i);
            if (sr_q[k]) acc = acc + ACC_W'(coef_i[idx]);
            else         acc = acc - ACC_W'(coef_i[idx]);
        end
    end

    always_comb begin
        sr_d = sr_q;
        tx_d = tx_q;
        if (en_i) begin
            if (acc > SAT_HI)      tx_d = {1'b0, {(OUT_W-1){1'b1}}};
            else if (acc < SAT_LO) tx_d = {1'b1, {(OUT_W-1){1'b0}}};
            else                   tx_d = acc[OUT_W-1:0];
            if (shift_i) sr_d = {sr_q[NBAUD-2:0], sym_i};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr_q <= '0;
            tx_q <= '0;
        end else begin
            sr_q <= sr_d;
            tx_q <= tx_d;
        end
    end

    assign tx_o = tx_q;

endmodule

// File: rtl/qpsk_tx_polyphase.sv
// Two-channel (I/Q) polyphase RRC transmit shaper; QPSK_TX_COEF_LOAD_EN adds a coefficient write port.
// Latency 1 clk from enable to o_valid; symbols are pulled with o_sym_rd, no other backpressure.
module qpsk_tx_polyphase
    import qpsk_tx_pkg::*;
#(
    parameter int OS     = 4,
    parameter int NBAUD  = 6,
    parameter int COEF_W = 8,
    parameter int OUT_W  = 8,
    parameter logic [OS*NBAUD*COEF_W-1:0] COEF = RRC_24x8
)(
    input logic                clk,
    input logic                rst,
    qpsk_tx_polyphase_if.slave bus
);

    localparam int NTAP = OS * NBAUD;
    localparam int PW   = clog2(OS);
    localparam int AW   = clog2(NTAP);

    logic [PW-1:0]            phase_q, phase_d;
    logic                     valid_q;
    logic                     wrap;
    logic signed [COEF_W-1:0] coef_rom [NTAP];
    logic signed [COEF_W-1:0] coef_q   [NTAP];

    for (genvar n = 0; n < NTAP; n++) begin : g_rom
        assign coef_rom[n] = COEF[(NTAP-1-n)*COEF_W +: COEF_W];
    end

`ifdef QPSK_TX_COEF_LOAD_EN
    logic signed [COEF_W-1:0] coef_d [NTAP];

    // Sums this cycle read coef_q, so a write only shows up from the next cycle on.
    always_comb begin
        coef_d = coef_q;
        if (bus.i_coef_we && ({1'b0, bus.i_coef_addr} < (AW+1)'(NTAP)))
            coef_d[bus.i_coef_addr] = bus.i_coef_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) coef_q <= coef_rom;
        else      coef_q <= coef_d;
    end
`else
    assign coef_q = coef_rom;
`endif

    assign wrap = (phase_q == PW'(OS - 1));

    always_comb begin
        phase_d = phase_q;
        if (bus.enable) phase_d = wrap ? '0 : phase_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q <= '0;
            valid_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
            valid_q <= bus.enable;
        end
    end

    assign bus.o_sym_rd = bus.enable & wrap;
    assign bus.o_valid  = valid_q;

    qpsk_tx_mac #(.OS(OS), .NBAUD(NBAUD), .COEF_W(COEF_W), .OUT_W(OUT_W)) u_mac_i (
        .clk     (clk),
        .rst     (rst),
        .en_i    (bus.enable),
        .shift_i (wrap),
        .phase_i (phase_q),
        .sym_i   (bus.i_sym_i),
        .coef_i  (coef_q),
        .tx_o    (bus.o_tx_i)
    );

    qpsk_tx_mac #(.OS(OS), .NBAUD(NBAUD), .COEF_W(COEF_W), .OUT_W(OUT_W)) u_mac_q (
        .clk     (clk),
        .rst     (rst),
        .en_i    (bus.enable),
        .shift_i (wrap),
        .phase_i (phase_q),
        .sym_i   (bus.i_sym_q),
        .coef_i  (coef_q),
        .tx_o    (bus.o_tx_q)
    );

endmodule

// File: tb/tb_qpsk_tx_polyphase.sv
// Bench for qpsk_tx_polyphase: default-COEF and all-0x7F instances driven in lockstep,
// a per-cycle reference model plus hand-computed literal expectations.
`timescale 1ns/1ps
module tb_qpsk_tx_polyphase;

    localparam int OS    = 4;
    localparam int NBAUD = 6;
    localparam int NTAP  = 24;
    localparam int CREF [NTAP] = '{-2, -2, -3, -1, 0, -8, -10, -12, -4, 18, 44, 64,
                                   72, 64, 44, 18, -4, -12, -10, -8, 0, -1, -3, -2};
    localparam int T1 [4] = '{62, 59, 62, 59};

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    qpsk_tx_polyphase_if ifa ();
    qpsk_tx_polyphase_if ifb ();

    assign ifb.enable  = ifa.enable;
    assign ifb.i_sym_i = ifa.i_sym_i;
    assign ifb.i_sym_q = ifa.i_sym_q;
`ifdef QPSK_TX_COEF_LOAD_EN
    assign ifb.i_coef_we   = 1'b0;
    assign ifb.i_coef_addr = '0;
    assign ifb.i_coef_data = '0;
`endif

    qpsk_tx_polyphase dut (.clk(clk), .rst(rst), .bus(ifa.slave));
    qpsk_tx_polyphase #(.COEF({24{8'h7F}})) dut_sat (.clk(clk), .rst(rst), .bus(ifb.slave));

    initial forever #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: symbol history as +/-1, phase as plain integer.
    int ca [NTAP];
    int cb [NTAP];
    int hi [NBAUD];
    int hq [NBAUD];
    int ph, ea_i, ea_q, eb_i, eb_q, ev;

    function automatic int sat8(input int y);
        if (y > 127)  return 127;
        if (y < -128) return -128;
        return y;
    endfunction

    function automatic int dot(input int c [NTAP], input int h [NBAUD], input int p);
        int s;
        s = 0;
        for (int k = 0; k < NBAUD; k++) s += h[k] * c[k*OS + p];
        return s;
    endfunction

    task automatic model_reset();
        ca = CREF;
        for (int n = 0; n < NTAP; n++) cb[n] = 127;
        for (int k = 0; k < NBAUD; k++) begin hi[k] = -1; hq[k] = -1; end
        ph = 0; ea_i = 0; ea_q = 0; eb_i = 0; eb_q = 0; ev = 0;
    endtask

    initial begin
        model_reset();
        forever begin
            @(negedge clk); #2;
            if (!rst) model_reset();
            chk("valid",     ifa.o_valid, ev);
            chk("valid_sat", ifb.o_valid, ev);
            chk("tx_i",      $signed(ifa.o_tx_i), ea_i);
            chk("tx_q",      $signed(ifa.o_tx_q), ea_q);
            chk("sat_tx_i",  $signed(ifb.o_tx_i), eb_i);
            chk("sat_tx_q",  $signed(ifb.o_tx_q), eb_q);
            chk("sym_rd",    ifa.o_sym_rd, (rst && ifa.enable && ph == OS-1) ? 1 : 0);
            if (rst) begin
                if (ifa.enable) begin
                    ea_i = sat8(dot(ca, hi, ph));
                    ea_q = sat8(dot(ca, hq, ph));
                    eb_i = sat8(dot(cb, hi, ph));
                    eb_q = sat8(dot(cb, hq, ph));
                    ev = 1;
                    if (ph == OS-1) begin
                        for (int k = NBAUD-1; k > 0; k--) begin hi[k] = hi[k-1]; hq[k] = hq[k-1]; end
                        hi[0] = ifa.i_sym_i ? 1 : -1;
                        hq[0] = ifa.i_sym_q ? 1 : -1;
                    end
                    ph = (ph + 1) % OS;
                end else begin
                    ev = 0;
                end
`ifdef QPSK_TX_COEF_LOAD_EN
                if (ifa.i_coef_we && int'(ifa.i_coef_addr) < NTAP)
                    ca[ifa.i_coef_addr] = int'($signed(ifa.i_coef_data));
`endif
            end
        end
    end

    task automatic cyc(input logic en, input logic si, input logic sq);
        @(negedge clk);
        ifa.enable  = en;
        ifa.i_sym_i = si;
        ifa.i_sym_q = sq;
`ifdef QPSK_TX_COEF_LOAD_EN
        ifa.i_coef_we = 1'b0;
`endif
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst = 1'b0;
        ifa.enable = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not reach its end");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd_cnt;
        ifa.enable = 1'b0; ifa.i_sym_i = 1'b0; ifa.i_sym_q = 1'b0;
`ifdef QPSK_TX_COEF_LOAD_EN
        ifa.i_coef_we = 1'b0; ifa.i_coef_addr = '0; ifa.i_coef_data = '0;
`endif
        repeat (2) @(negedge clk);
        #1;
        chk("rst_tx_i",   $signed(ifa.o_tx_i), 0);
        chk("rst_valid",  ifa.o_valid, 0);
        chk("rst_sym_rd", ifa.o_sym_rd, 0);
        @(negedge clk); rst = 1'b1;

        // All +1 symbols, then all -1, then I=+1/Q=-1, enable every cycle.
        for (int i = 0; i < 32; i++) begin
            cyc(1'b1, 1'b1, 1'b1);
            if (i >= 25) begin
                chk("t1_ones_i", $signed(ifa.o_tx_i), T1[(i-1)%4]);
                chk("t4_sat_hi", $signed(ifb.o_tx_i), 127);
            end
        end
        for (int i = 0; i < 32; i++) begin
            cyc(1'b1, 1'b0, 1'b0);
            if (i >= 25) begin
                chk("t2_zeros_q", $signed(ifa.o_tx_q), -T1[(i-1)%4]);
                chk("t4_sat_lo",  $signed(ifb.o_tx_q), -128);
            end
        end
        for (int i = 0; i < 32; i++) begin
            cyc(1'b1, 1'b1, 1'b0);
            if (i >= 25) begin
                chk("t2_mixed_i", $signed(ifa.o_tx_i), T1[(i-1)%4]);
                chk("t2_mixed_q", $signed(ifa.o_tx_q), -T1[(i-1)%4]);
            end
        end

        // Impulse on I: flush to -1, one +1 symbol, then walk it through all 24 taps.
        for (int i = 0; i < 32; i++) cyc(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)  cyc(1'b1, 1'b1, 1'b0);
        rd_cnt = 0;
        for (int j = 0; j < 25; j++) begin
            cyc(1'b1, 1'b0, 1'b0);
            #1;
            if (j < 24 && ifa.o_sym_rd) rd_cnt++;
            if (j >= 1) chk("t3_impulse", $signed(ifa.o_tx_i), -T1[(j-1)%4] + 2*CREF[j-1]);
        end
        chk("t3_sym_rd_count", rd_cnt, 6);

        // Sparse enable, one cycle in three.
        reset_pulse();
        for (int i = 0; i < 96; i++) begin
            cyc((i % 3) == 0, 1'b1, 1'b1);
            if ((i % 3) == 1 && (i-1)/3 >= 24) begin
                chk("t5_sparse_i",     $signed(ifa.o_tx_i), T1[((i-1)/3)%4]);
                chk("t5_sparse_valid", ifa.o_valid, 1);
            end
        end
        chk("t5_hold_i",     $signed(ifa.o_tx_i), 59);
        chk("t5_hold_valid", ifa.o_valid, 0);

        // Reset at phase 2: outputs clear at once and the phase restarts.
        reset_pulse();
        cyc(1'b1, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 1'b1);
        @(negedge clk);
        chk("t6_pre_rst_i", $signed(ifa.o_tx_i), -59);
        rst = 1'b0; ifa.enable = 1'b0;
        #1;
        chk("t6_rst_tx_i",  $signed(ifa.o_tx_i), 0);
        chk("t6_rst_tx_q",  $signed(ifa.o_tx_q), 0);
        chk("t6_rst_valid", ifa.o_valid, 0);
        @(negedge clk); rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b1, 1'b1);
            #1;
            chk("t6_restart_sym_rd", ifa.o_sym_rd, (i == 3) ? 1 : 0);
        end
        cyc(1'b0, 1'b1, 1'b1);
        chk("t6_restart_tx_i", $signed(ifa.o_tx_i), -59);

`ifdef QPSK_TX_COEF_LOAD_EN
        // c[12] cleared, out-of-range write ignored, then reset restores the default set.
        reset_pulse();
        @(negedge clk);
        ifa.enable = 1'b0; ifa.i_coef_we = 1'b1; ifa.i_coef_addr = 5'd12; ifa.i_coef_data = 8'sd0;
        @(negedge clk);
        ifa.i_coef_we = 1'b1; ifa.i_coef_addr = 5'd25; ifa.i_coef_data = 8'sd85;
        for (int i = 0; i < 28; i++) begin
            cyc(1'b1, 1'b1, 1'b1);
            if (i >= 25) chk("t6_coef_write", $signed(ifa.o_tx_i), ((i-1)%4 == 0) ? -10 : T1[(i-1)%4]);
        end
        reset_pulse();
        for (int i = 0; i < 28; i++) begin
            cyc(1'b1, 1'b1, 1'b1);
            if (i >= 25) chk("t6_coef_restore", $signed(ifa.o_tx_i), T1[(i-1)%4]);
        end
`endif

        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
